// File: rtl/source.sv
// Two-phase req/ack traffic generator: emits PACKETS payload words with a programmable gap.
// Optional build macro SOURCE_LFSR_EN selects a 32-bit Galois LFSR payload instead of a counter.
module source #(
  parameter int unsigned ID      = 0,
  parameter int unsigned SIZE    = 8,
  parameter int unsigned PACKETS = 16,
  parameter int unsigned GAP     = 0,
  parameter int unsigned SEED    = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic            ack,
  output logic            req,
  output logic [SIZE-1:0] data,
  output logic [31:0]     count,
  output logic            done,
  output logic            err
);

  localparam int unsigned id_unused = ID;
  localparam int unsigned GAP_W     = 16;

`ifdef SOURCE_LFSR_EN
  localparam int unsigned     SEQ_W     = 32;
  localparam logic [31:0]     LFSR_MASK = 32'h80200003;
  localparam logic [SEQ_W-1:0] SEQ_INIT = (SEED == 0) ? 32'd1 : 32'(SEED);
`else
  localparam int unsigned      SEQ_W    = SIZE;
  localparam logic [SEQ_W-1:0] SEQ_INIT = SEQ_W'(SEED);
`endif

  localparam logic [GAP_W-1:0] GAP_INIT   = GAP_W'(GAP);
  localparam logic [GAP_W-1:0] GAP_RELOAD = (GAP == 0) ? {GAP_W{1'b0}} : GAP_W'(GAP - 1);

  localparam logic [1:0] ST_GAP  = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [SEQ_W-1:0] seq_q, seq_d, seq_adv;
  logic             req_q, req_d;
  logic [SIZE-1:0]  data_q, data_d;
  logic [31:0]      count_q, count_d, count_inc;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             ack_old_q, ack_old_d;

  // Payload sequence advance
  always_comb begin
`ifdef SOURCE_LFSR_EN
    seq_adv = seq_q[0] ? ((seq_q >> 1) ^ LFSR_MASK) : (seq_q >> 1);
`else
    seq_adv = seq_q + SEQ_W'(1);
`endif
  end

  assign count_inc = count_q + 32'd1;

  // Next-state and output logic
  always_comb begin
    state_d   = state_q;
    gap_d     = gap_q;
    seq_d     = seq_q;
    req_d     = req_q;
    data_d    = data_q;
    count_d   = count_q;
    done_d    = done_q;
    err_d     = err_q;
    ack_old_d = ack;

    // An ack edge is only legal while a request is outstanding
    if ((ack != ack_old_q) && (state_q != ST_WAIT)) begin
      err_d = 1'b1;
    end

    case (state_q)
      ST_GAP: begin
        if (en) begin
          if (gap_q == '0) begin
            data_d  = seq_q[SIZE-1:0];
            req_d   = ~req_q;
            seq_d   = seq_adv;
            state_d = ST_WAIT;
          end else begin
            gap_d = gap_q - GAP_W'(1);
          end
        end
      end
      ST_WAIT: begin
        if (ack == req_q) begin
          count_d = count_inc;
          if ((PACKETS != 0) && (count_inc == 32'(PACKETS))) begin
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else if ((GAP == 0) && en) begin
            data_d = seq_q[SIZE-1:0];
            req_d  = ~req_q;
            seq_d  = seq_adv;
          end else begin
            gap_d   = GAP_RELOAD;
            state_d = ST_GAP;
          end
        end
      end
      ST_DONE: begin
      end
      default: begin
        state_d = ST_GAP;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_GAP;
      gap_q     <= GAP_INIT;
      seq_q     <= SEQ_INIT;
      req_q     <= 1'b0;
      data_q    <= '0;
      count_q   <= 32'd0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      ack_old_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gap_q     <= gap_d;
      seq_q     <= seq_d;
      req_q     <= req_d;
      data_q    <= data_d;
      count_q   <= count_d;
      done_q    <= done_d;
      err_q     <= err_d;
      ack_old_q <= ack_old_d;
    end
  end

  assign req   = req_q;
  assign data  = data_q;
  assign count = count_q;
  assign done  = done_q;
  assign err   = err_q;

endmodule

// File: tb/tb_source.sv
// Bench for source: three instances (GAP=0 bounded, GAP=3 bounded, GAP=0 unlimited) with a
// scoreboard of expected (edge, payload) pairs per request toggle.
module tb_source;

  typedef struct {
    int unsigned edge_n;
    logic [7:0]  data;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        en_r     [3];
  logic        ack_r    [3];
  logic        req_w    [3];
  logic [7:0]  data_w   [3];
  logic [31:0] count_w  [3];
  logic        done_w   [3];
  logic        err_w    [3];

  logic        pipe     [3];
  logic        hold     [3];
  logic        last_req [3];
  exp_t        sb       [3][$];

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned edge_n = 0;
  logic [31:0] s;
  logic [7:0]  c_v1;

  always #5 clk = ~clk;

  source #(.ID(0), .SIZE(8), .PACKETS(4), .GAP(0), .SEED(32'h10)) u_a (
    .clk(clk), .reset(reset), .en(en_r[0]), .ack(ack_r[0]), .req(req_w[0]),
    .data(data_w[0]), .count(count_w[0]), .done(done_w[0]), .err(err_w[0]));

  source #(.ID(1), .SIZE(8), .PACKETS(2), .GAP(3), .SEED(0)) u_b (
    .clk(clk), .reset(reset), .en(en_r[1]), .ack(ack_r[1]), .req(req_w[1]),
    .data(data_w[1]), .count(count_w[1]), .done(done_w[1]), .err(err_w[1]));

  source #(.ID(2), .SIZE(8), .PACKETS(0), .GAP(0), .SEED(1)) u_c (
    .clk(clk), .reset(reset), .en(en_r[2]), .ack(ack_r[2]), .req(req_w[2]),
    .data(data_w[2]), .count(count_w[2]), .done(done_w[2]), .err(err_w[2]));

  function automatic logic [31:0] seq_seed(input logic [31:0] v);
`ifdef SOURCE_LFSR_EN
    return (v == 32'd0) ? 32'd1 : v;
`else
    return v;
`endif
  endfunction

  function automatic logic [31:0] seq_step(input logic [31:0] v);
`ifdef SOURCE_LFSR_EN
    return v[0] ? ((v >> 1) ^ 32'h80200003) : (v >> 1);
`else
    return v + 32'd1;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input int idx, input int unsigned e);
    exp_t t;
    t.edge_n = e;
    t.data   = s[7:0];
    sb[idx].push_back(t);
    s = seq_step(s);
  endtask

  // One clock: scoreboard any req toggles, then run the one-edge-latency sinks
  task automatic step();
    exp_t t;
    @(posedge clk);
    edge_n++;
    #1;
    for (int i = 0; i < 3; i++) begin
      if (req_w[i] !== last_req[i]) begin
        if (sb[i].size() == 0) begin
          check($sformatf("unexpected_toggle_%0d", i), 32'(edge_n), 32'hFFFFFFFF);
        end else begin
          t = sb[i].pop_front();
          check($sformatf("toggle_edge_%0d", i), 32'(edge_n), 32'(t.edge_n));
          check($sformatf("toggle_data_%0d", i), 32'(data_w[i]), 32'(t.data));
        end
        last_req[i] = req_w[i];
      end
      if (!hold[i]) ack_r[i] = pipe[i];
      pipe[i] = req_w[i];
    end
  endtask

  initial begin
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ack_r[i] = 1'b0; pipe[i] = 1'b0; hold[i] = 1'b0; last_req[i] = 1'b0;
    end
    en_r[0] = 1'b1; en_r[1] = 1'b1; en_r[2] = 1'b0;

    s = seq_seed(32'h10);
    push(0, 1); push(0, 3); push(0, 5); push(0, 7);
    s = seq_seed(32'h0);
    push(1, 4); push(1, 9);
    s = seq_seed(32'h1);
    push(2, 11); push(2, 13); push(2, 35); push(2, 37); push(2, 42);
    c_v1 = sb[2][1].data;

    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check("rst_req",   32'(req_w[i]),  32'd0);
      check("rst_data",  32'(data_w[i]), 32'd0);
      check("rst_count", count_w[i],     32'd0);
      check("rst_done",  32'(done_w[i]), 32'd0);
      check("rst_err",   32'(err_w[i]),  32'd0);
    end
    @(negedge clk);
    reset = 1'b1;
    edge_n = 0;

    // Edges 1..10: A back-to-back, B with gap, C held off by en=0
    repeat (5) begin step(); check("c_idle_req", 32'(req_w[2]), 32'd0); end
    step(); check("b_count_e6", count_w[1], 32'd1); check("c_idle_req", 32'(req_w[2]), 32'd0);
    step(); check("a_count_e7", count_w[0], 32'd3);
    step(); check("a_done_e8", 32'(done_w[0]), 32'd0); check("a_count_e8", count_w[0], 32'd3);
    step(); check("a_done_e9", 32'(done_w[0]), 32'd1); check("a_count_e9", count_w[0], 32'd4);
    step(); check("b_done_e10", 32'(done_w[1]), 32'd0); check("c_idle_req", 32'(req_w[2]), 32'd0);
    en_r[2] = 1'b1;
    step(); check("b_done_e11", 32'(done_w[1]), 32'd1); check("b_count_e11", count_w[1], 32'd2);
    step();
    step(); check("c_count_e13", count_w[2], 32'd1);

    // Sink stalls 20 edges: request must hold steady
    hold[2] = 1'b1;
    repeat (20) begin
      step();
      check("c_hold_req",   32'(req_w[2]),  32'd0);
      check("c_hold_data",  32'(data_w[2]), 32'(c_v1));
      check("c_hold_count", count_w[2],     32'd1);
    end
    hold[2] = 1'b0;
    step(); check("c_count_e34", count_w[2], 32'd1);
    step(); check("c_count_e35", count_w[2], 32'd2);
    step(); step(); check("c_count_e37", count_w[2], 32'd3);
    en_r[2] = 1'b0;
    step(); step(); check("c_count_e39", count_w[2], 32'd4); check("c_err_e39", 32'(err_w[2]), 32'd0);

    // Spurious ack toggle while idle in GAP
    hold[2] = 1'b1; ack_r[2] = 1'b1;
    step(); check("c_err_e40", 32'(err_w[2]), 32'd1); check("c_count_e40", count_w[2], 32'd4);
    step(); check("c_err_e41", 32'(err_w[2]), 32'd1); check("c_req_e41", 32'(req_w[2]), 32'd0);
    ack_r[2] = 1'b0; hold[2] = 1'b0; en_r[2] = 1'b1;
    step(); check("c_err_e42", 32'(err_w[2]), 32'd1); check("c_count_e42", count_w[2], 32'd4);
    check("c_req_e42", 32'(req_w[2]), 32'd1);
    check("a_err_final", 32'(err_w[0]), 32'd0);
    check("b_err_final", 32'(err_w[1]), 32'd0);
    check("a_done_hold", 32'(done_w[0]), 32'd1);
    for (int i = 0; i < 3; i++) check($sformatf("sb_empty_%0d", i), 32'(sb[i].size()), 32'd0);

    // Asynchronous reset with C mid-transaction
    #2 reset = 1'b0;
    #1;
    check("arst_c_req",   32'(req_w[2]),  32'd0);
    check("arst_c_data",  32'(data_w[2]), 32'd0);
    check("arst_c_count", count_w[2],     32'd0);
    check("arst_c_err",   32'(err_w[2]),  32'd0);
    check("arst_a_done",  32'(done_w[0]), 32'd0);
    check("arst_a_count", count_w[0],     32'd0);
    for (int i = 0; i < 3; i++) begin
      ack_r[i] = 1'b0; pipe[i] = 1'b0; hold[i] = 1'b0; last_req[i] = 1'b0;
      sb[i].delete();
    end
    s = seq_seed(32'h10); push(0, 1);
    s = seq_seed(32'h1);  push(2, 1);
    @(negedge clk);
    reset = 1'b1;
    edge_n = 0;
    step(); step();
    check("restart_c_req",   32'(req_w[2]), 32'd1);
    check("restart_c_count", count_w[2],    32'd0);
    for (int i = 0; i < 3; i++) check($sformatf("sb_restart_empty_%0d", i), 32'(sb[i].size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
